// File: rtl/write_buffered_if.sv
// -----------------------------------------------------------------------------
// write_buffered_if
//   Bundles the execute-side result bus, the memory store port and the
//   architectural state outputs of the buffered write-back stage.
//
//   Execute side : in_valid, in_pc, in_adjustment, in_dest_value,
//                  in_destination, in_dest_is_memory, in_has_flushed -> stage
//                  in_hold                                           <- stage
//   Memory side  : mem_address, mem_data, mem_write                  <- stage
//                  mem_ready                                         -> stage
//   State        : output_registers, has_flushed, drained            <- stage
//
//   Modports: slave  = the write-back stage
//             master = whatever drives execute results and serves memory
// -----------------------------------------------------------------------------
interface write_buffered_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NR    = 16
);
  localparam int unsigned RW = $clog2(NR);

  logic                 in_valid;
  logic [WIDTH-1:0]     in_pc;
  logic [WIDTH-1:0]     in_adjustment;
  logic [WIDTH-1:0]     in_dest_value;
  logic [RW-1:0]        in_destination;
  logic                 in_dest_is_memory;
  logic                 in_has_flushed;
  logic                 in_hold;

  logic [WIDTH-1:0]     mem_address;
  logic [WIDTH-1:0]     mem_data;
  logic                 mem_write;
  logic                 mem_ready;

  logic [NR*WIDTH-1:0]  output_registers;
  logic                 has_flushed;
  logic                 drained;

  modport slave (
    input  in_valid, in_pc, in_adjustment, in_dest_value, in_destination,
           in_dest_is_memory, in_has_flushed, mem_ready,
    output in_hold, mem_address, mem_data, mem_write,
           output_registers, has_flushed, drained
  );

  modport master (
    output in_valid, in_pc, in_adjustment, in_dest_value, in_destination,
           in_dest_is_memory, in_has_flushed, mem_ready,
    input  in_hold, mem_address, mem_data, mem_write,
           output_registers, has_flushed, drained
  );
endinterface

// File: rtl/write_buffered.sv
// -----------------------------------------------------------------------------
// write_buffered
//   Write-back stage with a DEPTH-entry store buffer. Accepted execute results
//   commit to the register file and PC; stores are queued in a FIFO that drains
//   to memory on its own, so execute only stalls when a store meets a full
//   buffer that is not popping this cycle.
//
//   Ports:
//     clock  - rising-edge clock
//     reset  - synchronous, active-high; also discards queued stores
//     bus    - write_buffered_if.slave (execute bus, memory port, state)
//
//   Parameters: WIDTH, NR (r0 reads as zero), PC_INDEX, DEPTH (>=1, any
//   value), RESET_PC.
// -----------------------------------------------------------------------------
module write_buffered #(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       NR       = 16,
  parameter int unsigned       PC_INDEX = NR - 1,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input logic             clock,
  input logic             reset,
  write_buffered_if.slave bus
);

  localparam int unsigned RW = $clog2(NR);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [PW-1:0]    ptr_t;
  typedef logic [CW-1:0]    cnt_t;

  typedef struct packed {
    word_t addr;
    word_t data;
  } store_t;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  word_t  regs_q  [NR];
  word_t  regs_d  [NR];
  store_t buf_q   [DEPTH];
  ptr_t   head_q, head_d;
  ptr_t   tail_q, tail_d;
  cnt_t   count_q, count_d;
  logic   has_flushed_q;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic   full, accept, push, pop, dest_ok;
  word_t  store_data;

  assign full    = (count_q == cnt_t'(DEPTH));
  assign dest_ok = (int'(bus.in_destination) < int'(NR));

  // Holding on mem_ready (not on pop) keeps the execute path free of the
  // head-valid term; when full the head is valid anyway.
  assign bus.in_hold = bus.in_valid & bus.in_dest_is_memory & ~bus.in_has_flushed
                     & full & ~bus.mem_ready;
  assign accept      = bus.in_valid & ~bus.in_hold & ~bus.in_has_flushed;
  assign push        = accept & bus.in_dest_is_memory;
  assign pop         = bus.mem_write & bus.mem_ready;

  // Store data is the register value before this edge; r0 is never written,
  // so it naturally reads as zero.
  assign store_data  = dest_ok ? regs_q[bus.in_destination] : '0;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its default first, so no path can leave one
    // unassigned and infer a latch.
    regs_d  = regs_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (accept) begin
      if (!bus.in_dest_is_memory && dest_ok && bus.in_destination != '0)
        regs_d[bus.in_destination] = bus.in_dest_value;
      // A non-store targeting the PC is a branch: its value wins over the
      // sequential increment.
      if (!bus.in_dest_is_memory && bus.in_destination == RW'(PC_INDEX))
        regs_d[PC_INDEX] = bus.in_dest_value;
      else
        regs_d[PC_INDEX] = bus.in_pc + bus.in_adjustment;
    end

    if (push) tail_d = ptr_next(tail_q);
    if (pop)  head_d = ptr_next(head_q);

    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      for (int i = 0; i < int'(NR); i++) regs_q[i] <= '0;
      regs_q[PC_INDEX] <= RESET_PC;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      has_flushed_q    <= 1'b0;
    end else begin
      regs_q           <= regs_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      has_flushed_q    <= bus.in_valid & bus.in_has_flushed;
    end
  end

  // NOTE: the buffer storage is not reset; an entry is only observable once
  // count says it is valid, and the memory outputs are gated on that.
  always_ff @(posedge clock) begin
    if (push) buf_q[tail_q] <= '{addr: bus.in_dest_value, data: store_data};
  end

  // ---------------------------------------------------------------------------
  // Outputs: all driven from registers, no input-to-output path.
  // ---------------------------------------------------------------------------
  assign bus.mem_write   = (count_q != '0);
  assign bus.mem_address = bus.mem_write ? buf_q[head_q].addr : '0;
  assign bus.mem_data    = bus.mem_write ? buf_q[head_q].data : '0;
  assign bus.drained     = (count_q == '0);
  assign bus.has_flushed = has_flushed_q;

  always_comb begin
    bus.output_registers = '0;
    for (int i = 0; i < int'(NR); i++)
      bus.output_registers[i*WIDTH +: WIDTH] = regs_q[i];
  end

endmodule
